// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Requests win through a round-robin arbiter, pass through an issue register
// (I) that drives the ALU, and the results are captured in a result register
// (R) that is returned over a valid/ready handshake.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties and
// the round-robin pointer is removed.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A valid must not wait for its ready. A ready may depend on the valids.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rq0_valid,
    input  logic             rq1_valid,
    output logic             rq0_ready,
    output logic             rq1_ready,
    input  logic [31:0]      rq0_a,
    input  logic [31:0]      rq0_b,
    input  logic [31:0]      rq1_a,
    input  logic [31:0]      rq1_b,
    input  logic [2:0]       rq0_ctrl,
    input  logic [2:0]       rq1_ctrl,
    output logic             rs0_valid,
    output logic             rs1_valid,
    input  logic             rs0_ready,
    input  logic             rs1_ready,
    output logic [31:0]      rs_out,
    output logic             rs_z,
    output logic             rs_n,
    output logic             rs_err,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_control,
    input  logic [31:0]      alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    // Issue register
    logic             i_valid_q, i_valid_d;
    logic             i_sel_q,   i_sel_d;
    logic [31:0]      i_a_q,     i_a_d;
    logic [31:0]      i_b_q,     i_b_d;
    logic [2:0]       i_ctrl_q,  i_ctrl_d;
    // Result register
    logic             r_valid_q, r_valid_d;
    logic             r_sel_q,   r_sel_d;
    logic [31:0]      r_out_q,   r_out_d;
    logic             r_z_q,     r_z_d;
    logic             r_n_q,     r_n_d;
    logic             r_err_q,   r_err_d;
    // Grant counters
    logic [CNT_W-1:0] cnt0_q,    cnt0_d;
    logic [CNT_W-1:0] cnt1_q,    cnt1_d;

    logic r_adv, i_adv, win0, win1, hs0, hs1, grant, illegal;

    // R frees when empty or when its owner takes the result; I frees when R does.
    assign r_adv = ~r_valid_q | (r_sel_q ? rs1_ready : rs0_ready);
    assign i_adv = ~i_valid_q | r_adv;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 always wins when both are valid.
    assign win0 = rq0_valid;
`else
    logic last_q, last_d;
    // On a tie, the requester that did not win the last handshake goes first.
    assign win0   = rq0_valid & (~rq1_valid | last_q);
    assign last_d = grant ? hs1 : last_q;
`endif
    assign win1 = rq1_valid & ~win0;

    assign rq0_ready = win0 & i_adv;
    assign rq1_ready = win1 & i_adv;
    assign hs0       = rq0_valid & rq0_ready;
    assign hs1       = rq1_valid & rq1_ready;
    assign grant     = hs0 | hs1;

    // Codes 011, 100 and 101 are not ALU operations.
    assign illegal = (i_ctrl_q == 3'b011) | (i_ctrl_q == 3'b100) | (i_ctrl_q == 3'b101);

    // Issue register next state: load on a grant, empty when it drains with no grant.
    always_comb begin
        i_valid_d = i_valid_q;
        i_sel_d   = i_sel_q;
        i_a_d     = i_a_q;
        i_b_d     = i_b_q;
        i_ctrl_d  = i_ctrl_q;
        if (i_adv) begin
            i_valid_d = grant;
            if (grant) begin
                i_sel_d  = hs1;
                i_a_d    = hs1 ? rq1_a    : rq0_a;
                i_b_d    = hs1 ? rq1_b    : rq0_b;
                i_ctrl_d = hs1 ? rq1_ctrl : rq0_ctrl;
            end
        end
    end

    // Result register next state: capture the ALU outcome when I moves forward.
    always_comb begin
        r_valid_d = r_valid_q;
        r_sel_d   = r_sel_q;
        r_out_d   = r_out_q;
        r_z_d     = r_z_q;
        r_n_d     = r_n_q;
        r_err_d   = r_err_q;
        if (r_adv) begin
            r_valid_d = i_valid_q;
            if (i_valid_q) begin
                r_sel_d = i_sel_q;
                if (illegal) begin
                    r_out_d = 32'd0;
                    r_z_d   = 1'b1;
                    r_n_d   = 1'b0;
                    r_err_d = 1'b1;
                end else begin
                    r_out_d = alu_out;
                    r_z_d   = alu_z;
                    r_n_d   = alu_n;
                    r_err_d = 1'b0;
                end
            end
        end
    end

    // Saturating grant counters, one per requester.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (hs0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
        if (hs1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_valid_q <= 1'b0;
            i_sel_q   <= 1'b0;
            i_a_q     <= 32'd0;
            i_b_q     <= 32'd0;
            i_ctrl_q  <= 3'd0;
            r_valid_q <= 1'b0;
            r_sel_q   <= 1'b0;
            r_out_q   <= 32'd0;
            r_z_q     <= 1'b0;
            r_n_q     <= 1'b0;
            r_err_q   <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            i_valid_q <= i_valid_d;
            i_sel_q   <= i_sel_d;
            i_a_q     <= i_a_d;
            i_b_q     <= i_b_d;
            i_ctrl_q  <= i_ctrl_d;
            r_valid_q <= r_valid_d;
            r_sel_q   <= r_sel_d;
            r_out_q   <= r_out_d;
            r_z_q     <= r_z_d;
            r_n_q     <= r_n_d;
            r_err_q   <= r_err_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin pointer; starts at 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    assign alu_a       = i_a_q;
    assign alu_b       = i_b_q;
    assign alu_control = i_ctrl_q;
    assign rs0_valid   = r_valid_q & ~r_sel_q;
    assign rs1_valid   = r_valid_q &  r_sel_q;
    assign rs_out      = r_out_q;
    assign rs_z        = r_z_q;
    assign rs_n        = r_n_q;
    assign rs_err      = r_err_q;
    assign gnt_cnt0    = cnt0_q;
    assign gnt_cnt1    = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the external ALU, drives directed and random
// traffic, and compares every cycle against a transaction-level reference
// (queue of accepted operations, occupancy-based readiness, round-robin rule).
module tb_alu_arbiter;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             rq0_valid = 0, rq1_valid = 0;
    logic             rq0_ready, rq1_ready;
    logic [31:0]      rq0_a = 0, rq0_b = 0, rq1_a = 0, rq1_b = 0;
    logic [2:0]       rq0_ctrl = 0, rq1_ctrl = 0;
    logic             rs0_valid, rs1_valid;
    logic             rs0_ready = 1, rs1_ready = 1;
    logic [31:0]      rs_out;
    logic             rs_z, rs_n, rs_err;
    logic [31:0]      alu_a, alu_b;
    logic [2:0]       alu_control;
    logic [31:0]      alu_out;
    logic             alu_z, alu_n;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq1_valid(rq1_valid),
        .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
        .rq0_a(rq0_a), .rq0_b(rq0_b), .rq1_a(rq1_a), .rq1_b(rq1_b),
        .rq0_ctrl(rq0_ctrl), .rq1_ctrl(rq1_ctrl),
        .rs0_valid(rs0_valid), .rs1_valid(rs1_valid),
        .rs0_ready(rs0_ready), .rs1_ready(rs1_ready),
        .rs_out(rs_out), .rs_z(rs_z), .rs_n(rs_n), .rs_err(rs_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // ---------------- ALU behaviour ----------------
    function automatic logic is_illegal(input logic [2:0] c);
        return (c == 3'b011) || (c == 3'b100) || (c == 3'b101);
    endfunction

    function automatic logic [31:0] alu_calc(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;  // must never reach a response
        endcase
    endfunction

    always_comb begin
        alu_out = alu_calc(alu_control, alu_a, alu_b);
        alu_z   = (alu_out == 32'd0);
        alu_n   = alu_out[31];
    end

    // Expected response: {sel, err, n, z, out}
    function automatic logic [35:0] exp_resp(input logic sel, input logic [2:0] c,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (is_illegal(c)) return {sel, 1'b1, 1'b0, 1'b1, 32'd0};
        r = alu_calc(c, a, b);
        return {sel, 1'b0, r[31], (r == 32'd0), r};
    endfunction

    // ---------------- scoreboard ----------------
    logic [35:0] exp_q[$];   // accepted operations, oldest first
    logic [66:0] op_q[$];    // {ctrl, a, b} of each accepted operation
    int          acc_q[$];   // edge number at which each was accepted
    int          cyc = 0;
    logic        last_m = 1'b1;
    int          cnt0_m = 0, cnt1_m = 0;
    logic        post_reset = 1'b0;
    int          n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete(); op_q.delete(); acc_q.delete();
        last_m = 1'b1; cnt0_m = 0; cnt1_m = 0; post_reset = 1'b1;
    endtask

    // One clock cycle: inputs are already driven; check, update model, advance.
    task automatic step();
        int          n;
        logic        head_sel, in_r, e_adv, e_w0, e_w1, head_rdy;
        logic [35:0] h;
        logic [66:0] t;
        #1;
        n        = exp_q.size();
        head_sel = (n > 0) ? exp_q[0][35] : 1'b0;
        in_r     = (n > 0) && (acc_q[0] < cyc);
        head_rdy = head_sel ? rs1_ready : rs0_ready;
        // Two operations in flight means both stages are full.
        e_adv    = (n < 2) || head_rdy;
`ifdef ALU_ARB_FIXED_PRIO_EN
        e_w0 = rq0_valid;
`else
        e_w0 = rq0_valid && (!rq1_valid || last_m == 1'b1);
`endif
        e_w1 = rq1_valid && !e_w0;

        check("rq0_ready", {31'd0, rq0_ready}, {31'd0, e_w0 & e_adv});
        check("rq1_ready", {31'd0, rq1_ready}, {31'd0, e_w1 & e_adv});
        check("rs0_valid", {31'd0, rs0_valid}, {31'd0, in_r & ~head_sel});
        check("rs1_valid", {31'd0, rs1_valid}, {31'd0, in_r &  head_sel});
        check("gnt_cnt0", 32'(gnt_cnt0), cnt0_m);
        check("gnt_cnt1", 32'(gnt_cnt1), cnt1_m);
        if (in_r) begin
            h = exp_q[0];
            check("rs_out", rs_out, h[31:0]);
            check("rs_z",   {31'd0, rs_z},   {31'd0, h[32]});
            check("rs_n",   {31'd0, rs_n},   {31'd0, h[33]});
            check("rs_err", {31'd0, rs_err}, {31'd0, h[34]});
        end
        if (n > 0 && acc_q[n-1] == cyc) begin
            t = op_q[n-1];
            check("alu_control", {29'd0, alu_control}, {29'd0, t[66:64]});
            check("alu_a", alu_a, t[63:32]);
            check("alu_b", alu_b, t[31:0]);
        end
        if (post_reset) begin
            check("rst_alu_a", alu_a, 32'd0);
            check("rst_alu_b", alu_b, 32'd0);
            check("rst_alu_ctrl", {29'd0, alu_control}, 32'd0);
            check("rst_rs_out", rs_out, 32'd0);
            check("rst_flags", {29'd0, rs_z, rs_n, rs_err}, 32'd0);
            post_reset = 1'b0;
        end

        if (!rst_n) begin
            model_reset();
        end else begin
            if (in_r && head_rdy) begin
                void'(exp_q.pop_front()); void'(op_q.pop_front()); void'(acc_q.pop_front());
            end
            if (e_w0 && e_adv) begin
                exp_q.push_back(exp_resp(1'b0, rq0_ctrl, rq0_a, rq0_b));
                op_q.push_back({rq0_ctrl, rq0_a, rq0_b});
                acc_q.push_back(cyc + 1);
                last_m = 1'b0;
                if (cnt0_m < CNT_MAX) cnt0_m++;
            end else if (e_w1 && e_adv) begin
                exp_q.push_back(exp_resp(1'b1, rq1_ctrl, rq1_a, rq1_b));
                op_q.push_back({rq1_ctrl, rq1_a, rq1_b});
                acc_q.push_back(cyc + 1);
                last_m = 1'b1;
                if (cnt1_m < CNT_MAX) cnt1_m++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_rq0(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        rq0_valid = v; rq0_ctrl = c; rq0_a = a; rq0_b = b;
    endtask

    task automatic drive_rq1(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        rq1_valid = v; rq1_ctrl = c; rq1_a = a; rq1_b = b;
    endtask

    task automatic idle(input int n);
        rq0_valid = 0; rq1_valid = 0; rs0_ready = 1; rs1_ready = 1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rq0_valid = 0; rq1_valid = 0;
        rst_n = 0; step(); rst_n = 1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 4));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0;
        repeat (2) @(negedge clk);
        model_reset();
        do_reset();

        // Single ADD 5 + 7 from requester 0
        drive_rq0(1, 3'b010, 32'd5, 32'd7); step();
        idle(1);
        check("add_rs0_valid", {31'd0, rs0_valid}, 32'd1);
        check("add_out", rs_out, 32'd12);
        check("add_flags", {30'd0, rs_z, rs_n}, 32'd0);
        check("add_cnt0", 32'(gnt_cnt0), 32'd1);
        idle(2);

        // Contention from reset: SUB 3-3 vs SLT 1<2
        do_reset();
        drive_rq0(1, 3'b110, 32'd3, 32'd3);
        drive_rq1(1, 3'b111, 32'd1, 32'd2);
        rs0_ready = 1; rs1_ready = 1;
        repeat (4) step();
        idle(3);
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("cont_cnt0", 32'(gnt_cnt0), 32'd3);
        check("cont_cnt1", 32'(gnt_cnt1), 32'd0);
`else
        check("cont_cnt0", 32'(gnt_cnt0), 32'd2);
        check("cont_cnt1", 32'(gnt_cnt1), 32'd2);
`endif

        // Backpressure on requester 0 results
        rs0_ready = 0; rs1_ready = 1;
        drive_rq0(1, 3'b010, 32'd10, 32'd20); step();
        drive_rq0(1, 3'b010, 32'd11, 32'd20); step();
        check("bp_hold1", rs_out, 32'd30);
        drive_rq0(1, 3'b010, 32'd12, 32'd20); step();
        check("bp_hold2", rs_out, 32'd30);
        check("bp_rs0_valid", {31'd0, rs0_valid}, 32'd1);
        check("bp_rq0_ready", {31'd0, rq0_ready}, 32'd0);
        idle(4);

        // Illegal code from requester 1
        drive_rq1(1, 3'b100, 32'd123, 32'd456); step();
        idle(1);
        check("ill_rs1_valid", {31'd0, rs1_valid}, 32'd1);
        check("ill_out", rs_out, 32'd0);
        check("ill_flags", {29'd0, rs_z, rs_n, rs_err}, 32'b101);
        idle(1);

        // Negative result: SUB 0-1
        drive_rq0(1, 3'b110, 32'd0, 32'd1); step();
        idle(1);
        check("neg_out", rs_out, 32'hFFFF_FFFF);
        check("neg_flags", {29'd0, rs_z, rs_n, rs_err}, 32'b010);
        idle(2);

        // Reset with both stages full
        rs0_ready = 0;
        drive_rq0(1, 3'b001, 32'hF0, 32'h0F); step();
        drive_rq0(1, 3'b000, 32'hFF, 32'h3C); step();
        do_reset();
        check("mid_rs0_valid", {31'd0, rs0_valid}, 32'd0);
        check("mid_cnt0", 32'(gnt_cnt0), 32'd0);
        idle(3);

        // Counter saturation: five grants into a 2-bit counter
        rs0_ready = 1;
        for (int i = 0; i < 5; i++) begin
            drive_rq0(1, 3'b010, 32'(i), 32'd1); step();
        end
        idle(2);
        check("sat_cnt0", 32'(gnt_cnt0), 32'd3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_rq0($urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), rnd_op(), rnd_op());
            drive_rq1($urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), rnd_op(), rnd_op());
            rs0_ready = $urandom_range(0, 99) < 70;
            rs1_ready = $urandom_range(0, 99) < 70;
            rst_n     = ($urandom_range(0, 299) != 0);
            step();
            rst_n = 1;
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
